// File: rtl/ble_crc24_check.sv
// Serial BLE CRC-24 receive checker: runs the transmitter's Galois LFSR over the
// PDU bits, shifts in the 24 received CRC bits and strobes a one-cycle verdict.
module ble_crc24_check #(
  parameter logic [23:0] POLY  = 24'h00065B,
  parameter int          LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [23:0]      init_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             bit_i,
  input  logic             bit_vld_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             crc_ok_o,
  output logic [23:0]      crc_o,
  output logic [23:0]      rx_crc_o
);

  localparam int CNT_W = LEN_W + 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PDU  = 2'd1,
    S_CRC  = 2'd2
  } state_t;

  state_t           r_state;
  logic [23:0]      r_lfsr;
  logic [23:0]      r_rx_crc;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [4:0]       r_crc_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_crc_ok;

  logic             w_fb;
  logic [23:0]      w_lfsr_next;
  logic [23:0]      w_rx_next;

  assign w_fb        = r_lfsr[23] ^ bit_i;
  assign w_lfsr_next = {r_lfsr[22:0], 1'b0} ^ (w_fb ? POLY : 24'h000000);
  assign w_rx_next   = {r_rx_crc[22:0], bit_i};

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, matching the hardware.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_lfsr    <= 24'h000000;
      r_rx_crc  <= 24'h000000;
      r_bit_cnt <= '0;
      r_crc_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_crc_ok  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort_i) begin
        // Abort outranks start; captured CRC values stay visible for debug.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else if (start_i) begin
        r_lfsr    <= init_i;
        r_rx_crc  <= 24'h000000;
        r_crc_ok  <= 1'b0;
        r_bit_cnt <= {len_i, 3'b000};
        r_crc_cnt <= '0;
        r_busy    <= 1'b1;
        r_state   <= (len_i != '0) ? S_PDU : S_CRC;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
          end
          S_PDU: begin
            if (bit_vld_i) begin
              r_lfsr    <= w_lfsr_next;
              r_bit_cnt <= r_bit_cnt - CNT_W'(1);
              if (r_bit_cnt == CNT_W'(1)) begin
                r_state   <= S_CRC;
                r_crc_cnt <= '0;
              end
            end
          end
          S_CRC: begin
            if (bit_vld_i) begin
              r_rx_crc  <= w_rx_next;
              r_crc_cnt <= r_crc_cnt + 5'd1;
              if (r_crc_cnt == 5'd23) begin
                r_done   <= 1'b1;
                r_crc_ok <= (r_lfsr == w_rx_next);
                r_busy   <= 1'b0;
                r_state  <= S_IDLE;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign crc_ok_o = r_crc_ok;
  assign crc_o    = r_lfsr;
  assign rx_crc_o = r_rx_crc;

endmodule

// File: tb/tb_ble_crc24_check.sv
// Scoreboard bench for ble_crc24_check: the reference CRC is a polynomial long
// division remainder, compared by a monitor whenever the DUT strobes done_o.
module tb_ble_crc24_check;

  localparam int          LEN_W = 8;
  localparam logic [23:0] POLY  = 24'h00065B;

  logic             clk_i;
  logic             rst_n_i;
  logic             start_i;
  logic [23:0]      init_i;
  logic [LEN_W-1:0] len_i;
  logic             bit_i;
  logic             bit_vld_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic             crc_ok_o;
  logic [23:0]      crc_o;
  logic [23:0]      rx_crc_o;

  ble_crc24_check #(.POLY(POLY), .LEN_W(LEN_W)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .init_i    (init_i),
    .len_i     (len_i),
    .bit_i     (bit_i),
    .bit_vld_i (bit_vld_i),
    .abort_i   (abort_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .crc_ok_o  (crc_ok_o),
    .crc_o     (crc_o),
    .rx_crc_o  (rx_crc_o)
  );

  typedef struct {
    logic        ok;
    logic [23:0] crc;
    logic [23:0] rx;
  } exp_t;

  exp_t sb_q[$];
  int   done_cyc_q[$];
  bit   msg_q[$];
  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t mon_e;
  int   mon_dc;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CRC as remainder of (init * x^n + M(x) * x^24) mod G(x), by long division.
  function automatic logic [23:0] ref_crc(input logic [23:0] init, input bit msg[$]);
    int          n;
    bit          d[];
    logic [23:0] r;
    n = msg.size();
    d = new[n + 24];
    for (int j = 0; j < n + 24; j++) d[j] = 1'b0;
    for (int i = 0; i < n; i++) d[i] = msg[i];
    for (int j = 0; j < 24; j++) d[j] = d[j] ^ init[23-j];
    for (int i = 0; i < n; i++) begin
      if (d[i]) begin
        d[i] = 1'b0;
        for (int k = 1; k <= 24; k++) d[i+k] = d[i+k] ^ POLY[24-k];
      end
    end
    for (int m = 0; m < 24; m++) r[23-m] = d[n+m];
    return r;
  endfunction

  // Monitor: every done_o strobe must match the oldest pending expectation.
  always @(negedge clk_i) begin
    if (rst_n_i && done_o) begin
      if (sb_q.size() == 0 || done_cyc_q.size() == 0) begin
        check("spurious_done", {31'd0, done_o}, 32'd0);
      end else begin
        mon_e  = sb_q.pop_front();
        mon_dc = done_cyc_q.pop_front();
        check("done_latency", cyc, mon_dc);
        check("crc_ok", {31'd0, crc_ok_o}, {31'd0, mon_e.ok});
        check("crc_o", {8'd0, crc_o}, {8'd0, mon_e.crc});
        check("rx_crc_o", {8'd0, rx_crc_o}, {8'd0, mon_e.rx});
        check("busy_at_done", {31'd0, busy_o}, 32'd0);
      end
    end
  end

  task automatic step(input logic s, input logic v, input logic b, input logic a);
    @(negedge clk_i);
    start_i   = s;
    bit_vld_i = v;
    bit_i     = b;
    abort_i   = a;
  endtask

  task automatic send_bit(input bit b, input bit gappy);
    int gaps;
    gaps = 0;
    while (gappy && gaps < 4 && $urandom_range(1) == 1) begin
      step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
      gaps++;
    end
    step(1'b0, 1'b1, b, 1'b0);
  endtask

  // Full packet; its verdict is queued up front, its done cycle after the last bit.
  task automatic run_packet(input logic [23:0] init, input int nbytes, input bit msg[$],
                            input logic [23:0] flip, input bit gappy);
    exp_t        e;
    logic [23:0] rx;
    e.crc = ref_crc(init, msg);
    rx    = e.crc ^ flip;
    e.rx  = rx;
    e.ok  = (flip == 24'h000000);
    sb_q.push_back(e);
    init_i = init;
    len_i  = LEN_W'(nbytes);
    step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
    foreach (msg[i]) send_bit(msg[i], gappy);
    for (int i = 23; i >= 0; i--) send_bit(rx[i], gappy);
    done_cyc_q.push_back(cyc + 1);
  endtask

  // Start a packet and feed only nbits random bits; no verdict is expected.
  task automatic partial(input logic [23:0] init, input int nbytes, input int nbits);
    bit b;
    msg_q.delete();
    init_i = init;
    len_i  = LEN_W'(nbytes);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      b = 1'($urandom_range(1));
      if (i < nbytes * 8) msg_q.push_back(b);
      step(1'b0, 1'b1, b, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check({tag, "_ok"}, {31'd0, crc_ok_o}, 32'd0);
    check({tag, "_crc"}, {8'd0, crc_o}, 32'd0);
    check({tag, "_rx"}, {8'd0, rx_crc_o}, 32'd0);
  endtask

  initial begin
    bit          empty_msg[$];
    bit          byte1_msg[$];
    bit          rnd_msg[$];
    logic [23:0] saved_crc;
    logic [23:0] init_r;
    logic [23:0] flip;
    int          nb;

    n_checks  = 0;
    n_errors  = 0;
    rst_n_i   = 1'b0;
    start_i   = 1'b0;
    init_i    = '0;
    len_i     = '0;
    bit_i     = 1'b0;
    bit_vld_i = 1'b0;
    abort_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_n_i = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Empty PDU: the CRC is the preset itself.
    run_packet(24'h555555, 0, empty_msg, 24'h000000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("empty_crc", {8'd0, crc_o}, 32'h00555555);
    check("empty_rx", {8'd0, rx_crc_o}, 32'h00555555);
    check("empty_ok", {31'd0, crc_ok_o}, 32'd1);

    byte1_msg = '{1, 0, 0, 0, 0, 0, 0, 0};
    run_packet(24'h000000, 1, byte1_msg, 24'h000000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("byte1_crc", {8'd0, crc_o}, 32'h00032D80);
    check("byte1_ok", {31'd0, crc_ok_o}, 32'd1);

    run_packet(24'h000000, 1, byte1_msg, 24'h000001, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("corrupt_rx", {8'd0, rx_crc_o}, 32'h00032D81);
    check("corrupt_ok", {31'd0, crc_ok_o}, 32'd0);

    run_packet(24'h000000, 1, byte1_msg, 24'h000000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("gapped_crc", {8'd0, crc_o}, 32'h00032D80);
    check("gapped_ok", {31'd0, crc_ok_o}, 32'd1);

    // Abort after 5 PDU bits: busy falls next cycle, LFSR keeps its value.
    init_r = 24'($urandom);
    partial(init_r, 2, 5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_crc_hold", {8'd0, crc_o}, {8'd0, ref_crc(init_r, msg_q)});
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);

    // Restart in the middle of the CRC phase.
    partial(24'($urandom), 1, 12);
    rnd_msg = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    run_packet(24'h555555, 2, rnd_msg, 24'h000000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_ok", {31'd0, crc_ok_o}, 32'd1);

    // Abort and start together: abort wins, nothing is reloaded.
    init_r = 24'($urandom);
    partial(init_r, 1, 3);
    saved_crc = ref_crc(init_r, msg_q);
    init_i    = 24'($urandom);
    len_i     = LEN_W'(1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_start_busy", {31'd0, busy_o}, 32'd0);
    check("abort_start_crc", {8'd0, crc_o}, {8'd0, saved_crc});
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("abort_start_idle", {31'd0, busy_o}, 32'd0);

    // Asynchronous reset mid-CRC phase, observed before the next clock edge.
    partial(24'($urandom), 1, 18);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n_i = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_packet(24'h555555, 1, byte1_msg, 24'h000000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_reset_ok", {31'd0, crc_ok_o}, 32'd1);

    // Randomised back-to-back packets: each start lands in the previous done cycle.
    for (int p = 0; p < 10; p++) begin
      nb = $urandom_range(3);
      rnd_msg.delete();
      for (int i = 0; i < nb * 8; i++) rnd_msg.push_back(1'($urandom_range(1)));
      flip = ($urandom_range(2) == 0) ? (24'h000001 << $urandom_range(23)) : 24'h000000;
      run_packet(24'($urandom), nb, rnd_msg, flip, 1'($urandom_range(1)));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
